// File: rtl/mmul_sequencer.sv
// Operand buffer and skewed edge scheduler for an NxN systolic minifloat array.
// Loads A/B in IDLE, feeds skewed lanes, waits for drain, then captures the result.
module mmul_sequencer #(
    parameter  int unsigned N       = 2,
    parameter  int unsigned DW      = 8,
    parameter  int unsigned HOP     = 2,
    parameter  int unsigned OUT_LAT = 2,
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ld_valid_i,
    input  logic                ld_sel_i,
    input  logic [IW-1:0]       ld_row_i,
    input  logic [IW-1:0]       ld_col_i,
    input  logic [DW-1:0]       ld_data_i,
    output logic                ld_ready_o,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                acc_clr_o,
    output logic [N*DW-1:0]     a_edge_o,
    output logic [N*DW-1:0]     b_edge_o,
    input  logic [N*N*DW-1:0]   res_in_i,
    output logic [N*N*DW-1:0]   res_out_o
);

    localparam int unsigned FEED_LEN  = N + HOP * (N - 1);
    localparam int unsigned DRAIN_LEN = HOP * (N - 1) + OUT_LAT;
    localparam int unsigned MAX_LEN   = (FEED_LEN > DRAIN_LEN) ? FEED_LEN : DRAIN_LEN;
    localparam int unsigned CW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FEED    = 2'd1,
        DRAIN   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     t_q, t_d;
    logic [DW-1:0]     a_buf_q [N][N];
    logic [DW-1:0]     b_buf_q [N][N];
    logic [DW-1:0]     a_buf_d [N][N];
    logic [DW-1:0]     b_buf_d [N][N];
    logic [N*DW-1:0]   a_edge_q, a_edge_d;
    logic [N*DW-1:0]   b_edge_q, b_edge_d;
    logic [N*N*DW-1:0] res_q;
    logic              acc_clr_q, done_q, busy_q, ld_ready_q;

    // Next state, buffer writes, and edge lanes for the upcoming cycle.
    // Edges use the post-write buffers so a load in the start cycle is seen.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        a_edge_d = '0;
        b_edge_d = '0;

        if (ld_valid_i && (state_q == IDLE) &&
            (32'(ld_row_i) < N) && (32'(ld_col_i) < N)) begin
            if (ld_sel_i) b_buf_d[ld_row_i][ld_col_i] = ld_data_i;
            else          a_buf_d[ld_row_i][ld_col_i] = ld_data_i;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FEED;
                    t_d     = '0;
                end
            end
            FEED: begin
                if (t_q == CW'(FEED_LEN - 1)) begin
                    state_d = DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + CW'(1);
                end
            end
            DRAIN: begin
                if (t_q == CW'(DRAIN_LEN - 1)) begin
                    state_d = CAPTURE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase

        if (state_d == FEED) begin
            for (int i = 0; i < int'(N); i++) begin
                for (int k = 0; k < int'(N); k++) begin
                    if (int'(t_d) == k + int'(HOP) * i) begin
                        a_edge_d[i*DW +: DW] = a_buf_d[i][k];
                        b_edge_d[i*DW +: DW] = b_buf_d[k][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            t_q        <= '0;
            a_edge_q   <= '0;
            b_edge_q   <= '0;
            res_q      <= '0;
            acc_clr_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ld_ready_q <= 1'b1;
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    a_buf_q[r][c] <= '0;
                    b_buf_q[r][c] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            a_buf_q    <= a_buf_d;
            b_buf_q    <= b_buf_d;
            a_edge_q   <= a_edge_d;
            b_edge_q   <= b_edge_d;
            acc_clr_q  <= (state_d == FEED) && (t_d == '0);
            done_q     <= (state_q == CAPTURE);
            busy_q     <= (state_d != IDLE);
            ld_ready_q <= (state_d == IDLE);
            if (state_q == CAPTURE) res_q <= res_in_i;
        end
    end

    assign ld_ready_o = ld_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign acc_clr_o  = acc_clr_q;
    assign a_edge_o   = a_edge_q;
    assign b_edge_o   = b_edge_q;
    assign res_out_o  = res_q;

endmodule

// File: tb/tb_mmul_sequencer.sv
// Directed self-checking bench for mmul_sequencer with N=2, HOP=2, OUT_LAT=2.
module tb_mmul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_sel, start;
    logic [0:0]  ld_row, ld_col;
    logic [7:0]  ld_data;
    logic        ld_ready, busy, done, acc_clr;
    logic [15:0] a_edge, b_edge;
    logic [31:0] res_in, res_out;
    logic [31:0] exp_res;

    int n_assert = 0;
    int n_fail   = 0;

    mmul_sequencer #(.N(2), .DW(8), .HOP(2), .OUT_LAT(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ld_valid_i (ld_valid),
        .ld_sel_i   (ld_sel),
        .ld_row_i   (ld_row),
        .ld_col_i   (ld_col),
        .ld_data_i  (ld_data),
        .ld_ready_o (ld_ready),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .acc_clr_o  (acc_clr),
        .a_edge_o   (a_edge),
        .b_edge_o   (b_edge),
        .res_in_i   (res_in),
        .res_out_o  (res_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic sel, input logic r, input logic c, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_row   = r;
        ld_col   = c;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    // Caller raises start in cycle 0; this checks cycles 1..10 against hand tables.
    task automatic run(input logic [7:0] a11, input logic [31:0] rin, input bit inject, input bit chain);
        logic [15:0] ea, eb;
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            case (c)
                1:       begin ea = 16'h0011;       eb = 16'h0031; end
                2:       begin ea = 16'h0012;       eb = 16'h0041; end
                3:       begin ea = 16'h2100;       eb = 16'h3200; end
                4:       begin ea = {a11, 8'h00};   eb = 16'h4200; end
                default: begin ea = 16'h0000;       eb = 16'h0000; end
            endcase
            chk($sformatf("a_edge c%0d", c), 64'(a_edge), 64'(ea));
            chk($sformatf("b_edge c%0d", c), 64'(b_edge), 64'(eb));
            chk($sformatf("acc_clr c%0d", c), 64'(acc_clr), 64'(c == 1));
            chk($sformatf("busy c%0d", c), 64'(busy), 64'(c <= 9));
            chk($sformatf("done c%0d", c), 64'(done), 64'(c == 10));
            chk($sformatf("ld_ready c%0d", c), 64'(ld_ready), 64'(c == 10));
            if (c == 10) exp_res = rin;
            chk($sformatf("res_out c%0d", c), 64'(res_out), 64'(exp_res));
            if (inject && c == 3) begin
                start    = 1'b1;
                ld_valid = 1'b1;
                ld_sel   = 1'b0;
                ld_row   = 1'b0;
                ld_col   = 1'b0;
                ld_data  = 8'h7F;
            end
            if (inject && c == 4) begin
                start    = 1'b0;
                ld_valid = 1'b0;
            end
            if (c == 8) res_in = rin;
            if (c == 10 && chain) start = 1'b1;
            if (c < 10) tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_row   = 1'b0;
        ld_col   = 1'b0;
        ld_data  = 8'h00;
        start    = 1'b0;
        res_in   = 32'h0;
        exp_res  = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst ld_ready", 64'(ld_ready), 64'(1));
        chk("rst acc_clr", 64'(acc_clr), 64'(0));
        chk("rst a_edge", 64'(a_edge), 64'(0));
        chk("rst b_edge", 64'(b_edge), 64'(0));
        chk("rst res_out", 64'(res_out), 64'(0));

        load(1'b0, 1'b0, 1'b0, 8'h11);
        load(1'b0, 1'b0, 1'b1, 8'h12);
        load(1'b0, 1'b1, 1'b0, 8'h21);
        load(1'b0, 1'b1, 1'b1, 8'h22);
        load(1'b1, 1'b0, 1'b0, 8'h31);
        load(1'b1, 1'b0, 1'b1, 8'h32);
        load(1'b1, 1'b1, 1'b0, 8'h41);
        load(1'b1, 1'b1, 1'b1, 8'h42);
        chk("idle a_edge", 64'(a_edge), 64'(0));
        chk("idle busy", 64'(busy), 64'(0));

        // Skew and completion run.
        start = 1'b1;
        run(8'h22, 32'h3F3E3D3C, 1'b0, 1'b0);
        tick();
        chk("res hold", 64'(res_out), 64'(32'h3F3E3D3C));
        chk("done one-shot", 64'(done), 64'(0));

        // Start and load during FEED are ignored.
        start = 1'b1;
        run(8'h22, 32'h0A0B0C0D, 1'b1, 1'b0);
        tick();

        // Same-cycle load and start, then back-to-back restart in the done cycle.
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 1'b1;
        ld_col   = 1'b1;
        ld_data  = 8'h55;
        start    = 1'b1;
        run(8'h55, 32'h01020304, 1'b0, 1'b1);
        run(8'h55, 32'h05060708, 1'b0, 1'b0);
        tick();

        // Reset mid-FEED clears state, outputs and buffers.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre-rst busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mid rst busy", 64'(busy), 64'(0));
        chk("mid rst done", 64'(done), 64'(0));
        chk("mid rst a_edge", 64'(a_edge), 64'(0));
        chk("mid rst b_edge", 64'(b_edge), 64'(0));
        chk("mid rst res_out", 64'(res_out), 64'(0));
        chk("mid rst ld_ready", 64'(ld_ready), 64'(1));
        tick();
        chk("post rst busy", 64'(busy), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cleared acc_clr", 64'(acc_clr), 64'(1));
        chk("cleared a_edge", 64'(a_edge), 64'(0));
        chk("cleared b_edge", 64'(b_edge), 64'(0));
        chk("cleared busy", 64'(busy), 64'(1));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
